// File: rtl/alu_align_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_align_pkg                                                            |
// | Shared constants and helpers for the ALU output alignment buffer.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_align_pkg;

  // Width of every latency / alignment-point field.
  localparam int LAT_W = 3;

  // Width of the drop and mismatch counters.
  localparam int CNT_W = 16;

  // A record is the metadata followed by every channel field above it.
  function automatic int rec_width(input int num_ch, input int ch_w, input int meta_w);
    return meta_w + num_ch * ch_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_align_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_align_buffer_if                                                      |
// | Tag, channel, configuration and record-drain signals of the buffer.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface alu_align_buffer_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 8,
  parameter int HASH_W = 32,
  parameter int META_W = 128
) ();
  import alu_align_pkg::*;

  logic                                         tag_v;
  logic [HASH_W-1:0]                            tag_hash;
  logic [META_W-1:0]                            tag_meta;
  logic [NUM_CH-1:0]                            ch_v;
  logic [NUM_CH*CH_W-1:0]                       ch_data;
  logic [NUM_CH-1:0]                            ch_en;
  logic [NUM_CH*LAT_W-1:0]                      cfg_lat;
  logic [LAT_W-1:0]                             cfg_align;
  logic                                         out_valid;
  logic                                         out_ready;
  logic [HASH_W-1:0]                            out_addr;
  logic [rec_width(NUM_CH, CH_W, META_W)-1:0]   out_data;
  logic                                         busy;
  logic                                         cfg_err;
  logic [CNT_W-1:0]                             drop_cnt;
  logic [CNT_W-1:0]                             mism_cnt;

  // Producer / consumer side: tags, channel results, config and drain ready.
  modport master (
    output tag_v, tag_hash, tag_meta, ch_v, ch_data, ch_en, cfg_lat, cfg_align, out_ready,
    input  out_valid, out_addr, out_data, busy, cfg_err, drop_cnt, mism_cnt
  );

  // Alignment buffer side.
  modport slave (
    input  tag_v, tag_hash, tag_meta, ch_v, ch_data, ch_en, cfg_lat, cfg_align, out_ready,
    output out_valid, out_addr, out_data, busy, cfg_err, drop_cnt, mism_cnt
  );

endinterface
`default_nettype wire

// File: rtl/alu_align_buffer_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | align_delay_line                                                         |
// | Shift register with a runtime tap; tap 0 is the input itself. Also       |
// | exposes bit 0 of every stage so callers can see in-flight valids.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module align_delay_line
  import alu_align_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 7
) (
  input  wire              clk,
  input  wire              rst,
  input  wire [WIDTH-1:0]  din_i,
  input  wire [LAT_W-1:0]  tap_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [DEPTH-1:0] vld_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per cycle; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  // Tap k>0 is stage k-1; a tap beyond the line reads as zero.
  always_comb begin
    dout_o = '0;
    if (tap_i == '0) begin
      dout_o = din_i;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (int'(tap_i) == k) dout_o = stage_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_vld
    assign vld_o[k] = stage_q[k][0];
  end

endmodule
`default_nettype wire

// File: rtl/alu_align_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_align_buffer                                                         |
// | Re-aligns per-channel ALU results to their packet tag, assembles one     |
// | record per tag and buffers records toward the feature-memory writer.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_align_buffer
  import alu_align_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 8,
  parameter int HASH_W     = 32,
  parameter int META_W     = 128,
  parameter int MAX_LAT    = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  wire               clk,
  input  wire               rst,
  alu_align_buffer_if.slave bus
);

  localparam int REC_W  = rec_width(NUM_CH, CH_W, META_W);
  localparam int ENT_W  = HASH_W + REC_W;
  localparam int TAG_W  = META_W + HASH_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  // Tag path: {meta, hash, valid}, taken at the alignment point.
  logic [TAG_W-1:0]   tag_tap;
  logic [MAX_LAT-1:0] tag_stage_v;

  align_delay_line #(.WIDTH(TAG_W), .DEPTH(MAX_LAT)) u_tag_line (
    .clk    (clk),
    .rst    (rst),
    .din_i  ({bus.tag_meta, bus.tag_hash, bus.tag_v}),
    .tap_i  (bus.cfg_align),
    .dout_o (tag_tap),
    .vld_o  (tag_stage_v)
  );

  // Channel paths: {data, valid}; a channel arriving lat cycles after its tag
  // needs only align-lat further cycles of delay to meet the tag.
  logic [CH_W:0]             ch_tap [NUM_CH];
  logic [NUM_CH*MAX_LAT-1:0] ch_stage_v_unused;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [LAT_W-1:0] tap;
    assign tap = bus.cfg_align - bus.cfg_lat[i*LAT_W +: LAT_W];

    align_delay_line #(.WIDTH(CH_W + 1), .DEPTH(MAX_LAT)) u_ch_line (
      .clk    (clk),
      .rst    (rst),
      .din_i  ({bus.ch_data[i*CH_W +: CH_W], bus.ch_v[i]}),
      .tap_i  (tap),
      .dout_o (ch_tap[i]),
      .vld_o  (ch_stage_v_unused[i*MAX_LAT +: MAX_LAT])
    );
  end

  // Record assembly: enabled channels without a valid read as zero and flag a mismatch.
  logic              rec_v;
  logic              rec_miss;
  logic [HASH_W-1:0] rec_hash;
  logic [REC_W-1:0]  rec_data;

  always_comb begin
    rec_v    = tag_tap[0];
    rec_hash = tag_tap[HASH_W:1];
    rec_miss = 1'b0;
    rec_data = '0;
    rec_data[META_W-1:0] = tag_tap[TAG_W-1 -: META_W];
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_en[i]) begin
        if (ch_tap[i][0]) rec_data[META_W + i*CH_W +: CH_W] = ch_tap[i][CH_W:1];
        else              rec_miss = 1'b1;
      end
    end
  end

  // An enabled channel arriving after the alignment point can never be aligned.
  logic cfg_err_w;
  always_comb begin
    cfg_err_w = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_en[i] && (bus.cfg_lat[i*LAT_W +: LAT_W] > bus.cfg_align)) cfg_err_w = 1'b1;
    end
  end

  // Busy while any tag sits between the input and the alignment tap.
  logic busy_w;
  always_comb begin
    busy_w = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (k <= int'(bus.cfg_align)) busy_w = busy_w | tag_stage_v[k-1];
    end
  end

  // Record FIFO and counters.
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0]  drop_q, drop_d, mism_q, mism_d;
  logic              deq, full, enq;

  // Next-state: a dequeue in the same cycle frees the slot for a full-FIFO enqueue.
  always_comb begin
    deq      = (count_q != '0) && bus.out_ready;
    full     = (count_q == FCNT_W'(FIFO_DEPTH));
    enq      = rec_v && (!full || deq);
    wr_ptr_d = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    count_d  = count_q + FCNT_W'(enq) - FCNT_W'(deq);
    drop_d   = drop_q;
    mism_d   = mism_q;
    if (rec_v && !enq && (drop_q != '1))    drop_d = drop_q + CNT_W'(1);
    if (rec_v && rec_miss && (mism_q != '1)) mism_d = mism_q + CNT_W'(1);
  end

  // Register FIFO state and storage; reset empties everything including storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      mism_q   <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      mism_q   <= mism_d;
      if (enq) mem_q[wr_ptr_q] <= {rec_hash, rec_data};
    end
  end

  assign bus.out_valid               = (count_q != '0);
  assign {bus.out_addr, bus.out_data} = mem_q[rd_ptr_q];
  assign bus.busy                    = busy_w;
  assign bus.cfg_err                 = cfg_err_w;
  assign bus.drop_cnt                = drop_q;
  assign bus.mism_cnt                = mism_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_align_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_align_buffer                                                      |
// | Self-checking bench: directed scenarios plus randomized traffic against  |
// | a history/queue reference model.                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_align_buffer;

  localparam int ENT_W = 32 + 128 + 32;
  localparam int HL    = 4096;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat [4];

  alu_align_buffer_if #(.NUM_CH(4), .CH_W(8), .HASH_W(32), .META_W(128)) bus ();

  alu_align_buffer #(
    .NUM_CH(4), .CH_W(8), .HASH_W(32), .META_W(128), .MAX_LAT(7), .FIFO_DEPTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Keeps the input history per cycle; at each edge the tag from cycle
  // (now - align) is joined with each channel's input from cycle (tag + lat).
  logic             hv  [HL];
  logic [31:0]      hh  [HL];
  logic [127:0]     hm  [HL];
  logic [3:0]       hcv [HL];
  logic [31:0]      hcd [HL];
  int               cyc   = 0;
  int               epoch = 0;
  logic [ENT_W-1:0] mq [$];
  int               m_drop = 0;
  int               m_mism = 0;
  logic             m_deq, m_have, m_miss;
  logic [ENT_W-1:0] m_ent;
  int               mt, mc;

  always @(posedge clk) begin : model
    if (cyc >= HL) begin
      $display("FAIL model_history: got cycle %0d required below %0d", cyc, HL);
      $fatal(1);
    end
    hv[cyc]  = bus.tag_v;
    hh[cyc]  = bus.tag_hash;
    hm[cyc]  = bus.tag_meta;
    hcv[cyc] = bus.ch_v;
    hcd[cyc] = bus.ch_data;
    if (rst) begin
      mq.delete();
      m_drop = 0;
      m_mism = 0;
      epoch  = cyc + 1;
    end else begin
      m_deq  = (mq.size() != 0) && bus.out_ready;
      m_have = 1'b0;
      m_miss = 1'b0;
      m_ent  = '0;
      mt     = cyc - int'(bus.cfg_align);
      if (mt >= epoch && hv[mt]) begin
        m_have          = 1'b1;
        m_ent[191:160]  = hh[mt];
        m_ent[127:0]    = hm[mt];
        for (int i = 0; i < 4; i++) begin
          mc = mt + int'(bus.cfg_lat[i*3 +: 3]);
          if (bus.ch_en[i]) begin
            if (mc >= epoch && mc <= cyc && hcv[mc][i]) m_ent[128 + i*8 +: 8] = hcd[mc][i*8 +: 8];
            else m_miss = 1'b1;
          end
        end
      end
      if (m_deq) void'(mq.pop_front());
      if (m_have) begin
        if (mq.size() < 8) mq.push_back(m_ent);
        else if (m_drop < 65535) m_drop++;
        if (m_miss && m_mism < 65535) m_mism++;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.tag_v    = 1'b0;
    bus.tag_hash = '0;
    bus.tag_meta = '0;
    bus.ch_v     = '0;
    bus.ch_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_cfg(input int a, input int l0, input int l1, input int l2, input int l3,
                         input logic [3:0] en);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    bus.cfg_align = 3'(a);
    bus.cfg_lat   = {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
    bus.ch_en     = en;
  endtask

  // One tag, channel i driven with 8'h11*(i+1) exactly lat[i] cycles later when
  // vmask[i] is set; captures the first record seen and its latency.
  task automatic send_one(input logic [31:0] hash, input logic [3:0] vmask,
                          output int lat_seen, output logic [ENT_W-1:0] head);
    lat_seen = -1;
    head     = '0;
    for (int k = 0; k < 12; k++) begin
      bus.tag_v    = (k == 0);
      bus.tag_hash = hash;
      bus.tag_meta = {4{hash}};
      for (int i = 0; i < 4; i++) begin
        bus.ch_v[i]          = vmask[i] && (k == lat[i]);
        bus.ch_data[i*8 +: 8] = 8'(8'h11 * (i + 1));
      end
      tick();
      if (lat_seen < 0 && bus.out_valid) begin
        lat_seen = k + 1;
        head     = {bus.out_addr, bus.out_data};
      end
    end
    idle_inputs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    set_cfg(0, 0, 0, 0, 0, 4'h0);
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.out_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h required 0", bus.out_addr); end
    n_checks++; if (bus.out_data !== 160'h0) begin n_errors++; $display("FAIL reset_data: got %h required 0", bus.out_data); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    n_checks++; if (bus.drop_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_drop: got %0d required 0", bus.drop_cnt); end
    n_checks++; if (bus.mism_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_mism: got %0d required 0", bus.mism_cnt); end
  endtask

  task automatic test_basic();
    int lat_seen;
    logic [ENT_W-1:0] head;
    do_reset();
    set_cfg(4, 1, 2, 3, 4, 4'hF);
    bus.out_ready = 1'b1;
    send_one(32'hA5, 4'hF, lat_seen, head);
    n_checks++; if (lat_seen !== 5) begin n_errors++; $display("FAIL basic_latency: got %0d required 5", lat_seen); end
    n_checks++; if (head[191:160] !== 32'hA5) begin n_errors++; $display("FAIL basic_addr: got %h required a5", head[191:160]); end
    n_checks++; if (head[159:128] !== 32'h44332211) begin n_errors++; $display("FAIL basic_fields: got %h required 44332211", head[159:128]); end
    n_checks++; if (head[127:0] !== {4{32'hA5}}) begin n_errors++; $display("FAIL basic_meta: got %h required %h", head[127:0], {4{32'hA5}}); end
    n_checks++; if (bus.mism_cnt !== 16'd0) begin n_errors++; $display("FAIL basic_mism: got %0d required 0", bus.mism_cnt); end
  endtask

  task automatic test_back_to_back();
    int got, bubbles;
    bit started;
    do_reset();
    set_cfg(4, 1, 2, 3, 4, 4'hF);
    bus.out_ready = 1'b1;
    got = 0; bubbles = 0; started = 0;
    for (int k = 0; k < 40; k++) begin
      bus.tag_v    = (k < 20);
      bus.tag_hash = 32'h1000 + 32'(k);
      bus.tag_meta = {4{$urandom()}};
      bus.ch_v     = 4'hF;
      bus.ch_data  = $urandom();
      tick();
      n_checks++;
      if (bus.out_valid !== (mq.size() != 0)) begin
        n_errors++; $display("FAIL b2b_valid: got %b required %b", bus.out_valid, mq.size() != 0);
      end
      if (bus.out_valid === 1'b1) begin
        started = 1;
        n_checks++;
        if (mq.size() != 0 && {bus.out_addr, bus.out_data} !== mq[0]) begin
          n_errors++; $display("FAIL b2b_record: got %h required %h", {bus.out_addr, bus.out_data}, mq[0]);
        end
        n_checks++;
        if (bus.out_addr !== 32'h1000 + 32'(got)) begin
          n_errors++; $display("FAIL b2b_order: got %h required %h", bus.out_addr, 32'h1000 + 32'(got));
        end
        got++;
      end else if (started && got < 20) begin
        bubbles++;
      end
    end
    idle_inputs();
    n_checks++; if (got != 20) begin n_errors++; $display("FAIL b2b_count: got %0d required 20", got); end
    n_checks++; if (bubbles != 0) begin n_errors++; $display("FAIL b2b_bubbles: got %0d required 0", bubbles); end
    n_checks++; if (bus.drop_cnt !== 16'd0) begin n_errors++; $display("FAIL b2b_drop: got %0d required 0", bus.drop_cnt); end
  endtask

  task automatic test_missing();
    int lat_seen;
    logic [ENT_W-1:0] head;
    do_reset();
    set_cfg(4, 1, 2, 3, 4, 4'hF);
    bus.out_ready = 1'b1;
    send_one(32'hB6, 4'b1011, lat_seen, head);
    n_checks++; if (head[159:128] !== 32'h44002211) begin n_errors++; $display("FAIL miss_fields: got %h required 44002211", head[159:128]); end
    n_checks++; if (bus.mism_cnt !== 16'd1) begin n_errors++; $display("FAIL miss_cnt: got %0d required 1", bus.mism_cnt); end
    set_cfg(4, 1, 2, 3, 4, 4'b1011);
    send_one(32'hB7, 4'hF, lat_seen, head);
    n_checks++; if (head[191:160] !== 32'hB7) begin n_errors++; $display("FAIL dis_addr: got %h required b7", head[191:160]); end
    n_checks++; if (head[159:128] !== 32'h44002211) begin n_errors++; $display("FAIL dis_fields: got %h required 44002211", head[159:128]); end
    n_checks++; if (bus.mism_cnt !== 16'd1) begin n_errors++; $display("FAIL dis_cnt: got %0d required 1", bus.mism_cnt); end
  endtask

  task automatic test_overflow();
    int got;
    do_reset();
    set_cfg(4, 1, 2, 3, 4, 4'hF);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.tag_v = 1'b1; bus.tag_hash = 32'h2000 + 32'(k); bus.tag_meta = {4{$urandom()}};
      bus.ch_v = 4'hF; bus.ch_data = $urandom();
      tick();
    end
    idle_inputs();
    repeat (6) tick();
    n_checks++; if (bus.drop_cnt !== 16'd2) begin n_errors++; $display("FAIL ovf_drop: got %0d required 2", bus.drop_cnt); end
    n_checks++; if (bus.out_addr !== 32'h2000) begin n_errors++; $display("FAIL ovf_head: got %h required 2000", bus.out_addr); end
    bus.out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid === 1'b1) begin
        n_checks++;
        if (bus.out_addr !== 32'h2000 + 32'(got)) begin
          n_errors++; $display("FAIL ovf_order: got %h required %h", bus.out_addr, 32'h2000 + 32'(got));
        end
        got++;
      end
      tick();
    end
    n_checks++; if (got != 8) begin n_errors++; $display("FAIL ovf_drained: got %0d required 8", got); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_empty: got %b required 0", bus.out_valid); end
    // Fill with zero-latency alignment, then enqueue and dequeue together while full.
    set_cfg(0, 0, 0, 0, 0, 4'hF);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      bus.out_ready = (k >= 8);
      bus.tag_v = 1'b1; bus.tag_hash = 32'h3000 + 32'(k); bus.tag_meta = '0;
      bus.ch_v = 4'hF; bus.ch_data = $urandom();
      tick();
    end
    n_checks++; if (bus.drop_cnt !== 16'd2) begin n_errors++; $display("FAIL full_swap_drop: got %0d required 2", bus.drop_cnt); end
    n_checks++; if (bus.out_addr !== 32'h3003) begin n_errors++; $display("FAIL full_swap_head: got %h required 3003", bus.out_addr); end
    bus.out_ready = 1'b0;
    tick();
    n_checks++; if (bus.drop_cnt !== 16'd3) begin n_errors++; $display("FAIL full_drop: got %0d required 3", bus.drop_cnt); end
    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_cfg(4, 1, 2, 3, 4, 4'hF);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.tag_v    = (k < 2) || (k >= 6);
      bus.tag_hash = 32'h4000 + 32'(k);
      bus.ch_v     = 4'hF;
      bus.ch_data  = $urandom();
      tick();
    end
    idle_inputs();
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy_before: got %b required 1", bus.busy); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL mid_valid_before: got %b required 1", bus.out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy: got %b required 0", bus.busy); end
    n_checks++; if (bus.drop_cnt !== 16'd0 || bus.mism_cnt !== 16'd0) begin
      n_errors++; $display("FAIL mid_counters: got %0d/%0d required 0/0", bus.drop_cnt, bus.mism_cnt);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_stale: got %b required 0 at cycle %0d", bus.out_valid, k); end
    end
  endtask

  task automatic test_cfg_err();
    int lat_seen;
    logic [ENT_W-1:0] head;
    do_reset();
    bus.out_ready = 1'b1;
    set_cfg(4, 5, 2, 3, 4, 4'hF); #1;
    n_checks++; if (bus.cfg_err !== 1'b1) begin n_errors++; $display("FAIL cfgerr_set: got %b required 1", bus.cfg_err); end
    set_cfg(4, 5, 2, 3, 4, 4'b1110); #1;
    n_checks++; if (bus.cfg_err !== 1'b0) begin n_errors++; $display("FAIL cfgerr_disabled: got %b required 0", bus.cfg_err); end
    set_cfg(4, 4, 2, 3, 4, 4'hF); #1;
    n_checks++; if (bus.cfg_err !== 1'b0) begin n_errors++; $display("FAIL cfgerr_equal: got %b required 0", bus.cfg_err); end
    set_cfg(0, 0, 0, 0, 0, 4'hF); #1;
    send_one(32'hC0DE, 4'hF, lat_seen, head);
    n_checks++; if (lat_seen !== 1) begin n_errors++; $display("FAIL lat0_latency: got %0d required 1", lat_seen); end
    n_checks++; if (head[191:128] !== {32'hC0DE, 32'h44332211}) begin
      n_errors++; $display("FAIL lat0_record: got %h required %h", head[191:128], {32'hC0DE, 32'h44332211});
    end
  endtask

  task automatic test_random();
    int a;
    logic exp_busy;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      a = $urandom_range(0, 7);
      set_cfg(a, $urandom_range(0, a), $urandom_range(0, a), $urandom_range(0, a),
              $urandom_range(0, a), 4'($urandom()));
      for (int k = 0; k < 66; k++) begin
        bus.tag_v    = (k < 50) && ($urandom_range(0, 1) == 1);
        bus.tag_hash = $urandom();
        bus.tag_meta = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 4; i++) bus.ch_v[i] = (k < 50) && ($urandom_range(0, 3) != 0);
        bus.ch_data   = $urandom();
        bus.out_ready = (k >= 50) || ($urandom_range(0, 3) != 0);
        tick();
        exp_busy = 1'b0;
        for (int j = 1; j <= a; j++) if (cyc - j >= epoch && hv[cyc - j]) exp_busy = 1'b1;
        n_checks++; if (bus.out_valid !== (mq.size() != 0)) begin n_errors++; $display("FAIL rnd_valid: got %b required %b", bus.out_valid, mq.size() != 0); end
        if (mq.size() != 0) begin
          n_checks++; if ({bus.out_addr, bus.out_data} !== mq[0]) begin n_errors++; $display("FAIL rnd_record: got %h required %h", {bus.out_addr, bus.out_data}, mq[0]); end
        end
        n_checks++; if (bus.drop_cnt !== 16'(m_drop)) begin n_errors++; $display("FAIL rnd_drop: got %0d required %0d", bus.drop_cnt, m_drop); end
        n_checks++; if (bus.mism_cnt !== 16'(m_mism)) begin n_errors++; $display("FAIL rnd_mism: got %0d required %0d", bus.mism_cnt, m_mism); end
        n_checks++; if (bus.busy !== exp_busy) begin n_errors++; $display("FAIL rnd_busy: got %b required %b", bus.busy, exp_busy); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 4'h0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_missing();
    test_overflow();
    test_reset_mid();
    test_cfg_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
